shared_instr_mem: RTL and testbench

- Single-ported instruction memory shared by NUM_CORES processor cores of the matrix-multiply array.
- Round-robin arbitration serves one read address per cycle.
- Address merging: every requesting core with the same address as the winner is served in that cycle. This is the normal case when all cores run the same program.
- A loader write port fills the program before or between runs and takes priority over reads.

---
 rtl/shared_instr_mem.sv | 99 +++++++++
 tb/tb_shared_instr_mem.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/shared_instr_mem.sv
// Shared single-ported instruction memory for the matrix-multiply core array.
// One read address is served per cycle: a round-robin winner plus every other
// requesting core that asks for the same address. The loader write port
// pre-empts reads for the cycle it is active.
module shared_instr_mem #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned NUM_CORES = 8,
    parameter string       INIT_FILE = ""
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CORES-1:0]        req,
    input  logic [NUM_CORES*ADDR_W-1:0] addr,
    output logic [NUM_CORES-1:0]        grant,
    output logic [NUM_CORES-1:0]        rvalid,
    output logic [DATA_W-1:0]           rdata,
    output logic                        rerr,
    input  logic                        wr_en,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [DATA_W-1:0]           wr_data,
    output logic                        busy
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [ADDR_W:0]  DEPTH_LIM = (ADDR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_CORE = PTR_W'(NUM_CORES - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  win;
    logic [PTR_W-1:0]  ptr_next;
    logic              found;
    logic [ADDR_W-1:0] win_addr;
    logic              rd_in_range;
    logic              wr_in_range;

    // Circular search for the first requester at or above the pointer.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < int'(NUM_CORES); k++) begin
            logic [PTR_W-1:0] cand;
            cand = PTR_W'((32'(ptr) + 32'(k)) % NUM_CORES);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign win_addr    = addr[32'(win)*ADDR_W +: ADDR_W];
    assign rd_in_range = {1'b0, win_addr} < DEPTH_LIM;
    assign wr_in_range = {1'b0, wr_addr} < DEPTH_LIM;
    assign ptr_next    = (win == LAST_CORE) ? '0 : win + PTR_W'(1);

    // Grant the winner and every requester sharing its address; writes and reset block reads.
    always_comb begin
        grant = '0;
        if (rst_n && !wr_en && found) begin
            for (int j = 0; j < int'(NUM_CORES); j++) begin
                grant[j] = req[j] && (addr[j*ADDR_W +: ADDR_W] == win_addr);
            end
        end
    end

    // Registered read response, round-robin pointer and stall indicator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid <= '0;
            rdata  <= '0;
            rerr   <= 1'b0;
            busy   <= 1'b0;
            ptr    <= '0;
        end else begin
            busy <= |(req & ~grant);
            if (|grant) begin
                rvalid <= grant;
                rerr   <= !rd_in_range;
                rdata  <= rd_in_range ? mem[win_addr[IDX_W-1:0]] : '0;
                ptr    <= ptr_next;
            end else begin
                rvalid <= '0;
                rerr   <= 1'b0;
            end
        end
    end

    // Loader write port; storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en && wr_in_range) begin
            mem[wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

endmodule

// File: tb/tb_shared_instr_mem.sv
// Directed bench for shared_instr_mem: load, merge, round-robin, write priority,
// out-of-range handling and asynchronous reset in the middle of a read.
module tb_shared_instr_mem;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned NC     = 8;

    logic                 clk;
    logic                 rst_n;
    logic [NC-1:0]        req;
    logic [NC*ADDR_W-1:0] addr;
    logic [NC-1:0]        grant;
    logic [NC-1:0]        rvalid;
    logic [DATA_W-1:0]    rdata;
    logic                 rerr;
    logic                 wr_en;
    logic [ADDR_W-1:0]    wr_addr;
    logic [DATA_W-1:0]    wr_data;
    logic                 busy;

    int n_checks = 0;
    int n_fail   = 0;

    shared_instr_mem #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(256), .NUM_CORES(NC), .INIT_FILE("")
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .grant(grant),
        .rvalid(rvalid), .rdata(rdata), .rerr(rerr), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int core, input logic [ADDR_W-1:0] a);
        addr[core*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic load(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        req     = 8'hFF;
        addr    = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;

        // Reset state: nothing granted even with all cores requesting
        #1;
        check("rst_grant", 32'(grant), 32'h00);
        tick();
        tick();
        check("rst_rvalid", 32'(rvalid), 32'h00);
        check("rst_rdata", 32'(rdata), 32'h0000);
        check("rst_rerr", 32'(rerr), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Program load
        load(16'd7, 16'h0707);
        load(16'd12, 16'hABCD);
        load(16'd0, 16'h1111);
        load(16'd44, 16'h4444);

        // Merge: all cores on address 7, pointer 0 -> 1
        req = 8'hFF;
        for (int i = 0; i < int'(NC); i++) set_addr(i, 16'd7);
        #1;
        check("merge_grant", 32'(grant), 32'hFF);
        tick();
        check("merge_rvalid", 32'(rvalid), 32'hFF);
        check("merge_rdata", 32'(rdata), 32'h0707);
        check("merge_rerr", 32'(rerr), 32'h0);
        check("merge_busy", 32'(busy), 32'h0);

        // Pointer now 1: core 1 beats core 0
        req = 8'h03;
        set_addr(0, 16'd0);
        set_addr(1, 16'd12);
        #1;
        check("ptr1_grant", 32'(grant), 32'h02);
        tick();
        check("ptr1_rvalid", 32'(rvalid), 32'h02);
        check("ptr1_rdata", 32'(rdata), 32'hABCD);
        check("ptr1_busy", 32'(busy), 32'h1);
        req = 8'h01;
        #1;
        check("wrap_grant", 32'(grant), 32'h01);
        tick();
        check("wrap_rvalid", 32'(rvalid), 32'h01);
        check("wrap_rdata", 32'(rdata), 32'h1111);
        check("wrap_busy", 32'(busy), 32'h0);

        // Load then read: core 0 at address 12 (pointer 1, wraps to core 0)
        set_addr(0, 16'd12);
        #1;
        check("ld_grant", 32'(grant), 32'h01);
        tick();
        check("ld_rvalid", 32'(rvalid), 32'h01);
        check("ld_rdata", 32'(rdata), 32'hABCD);
        check("ld_rerr", 32'(rerr), 32'h0);

        // Core 7 alone moves the pointer back to 0
        req = 8'h80;
        set_addr(7, 16'd44);
        #1;
        check("c7_grant", 32'(grant), 32'h80);
        tick();
        check("c7_rdata", 32'(rdata), 32'h4444);
        req = '0;

        // Round-robin over distinct addresses 0..7
        for (int i = 0; i < int'(NC); i++) load(ADDR_W'(i), DATA_W'(16'h100 + i));
        req = 8'hFF;
        for (int i = 0; i < int'(NC); i++) set_addr(i, ADDR_W'(i));
        for (int i = 0; i < int'(NC); i++) begin
            #1;
            check($sformatf("rr%0d_grant", i), 32'(grant), 32'(1) << i);
            tick();
            check($sformatf("rr%0d_rvalid", i), 32'(rvalid), 32'(1) << i);
            check($sformatf("rr%0d_rdata", i), 32'(rdata), 32'h100 + 32'(i));
            check($sformatf("rr%0d_busy", i), 32'(busy), (i < int'(NC) - 1) ? 32'h1 : 32'h0);
            req[i] = 1'b0;
        end

        // Write priority: core 3 reads address 5 while the loader writes it
        req = 8'h08;
        set_addr(3, 16'd5);
        wr_en   = 1'b1;
        wr_addr = 16'd5;
        wr_data = 16'h5555;
        #1;
        check("wp_grant_blocked", 32'(grant), 32'h00);
        tick();
        wr_en = 1'b0;
        check("wp_rvalid_none", 32'(rvalid), 32'h00);
        check("wp_busy", 32'(busy), 32'h1);
        #1;
        check("wp_grant", 32'(grant), 32'h08);
        tick();
        check("wp_rvalid", 32'(rvalid), 32'h08);
        check("wp_rdata", 32'(rdata), 32'h5555);

        // Out-of-range read: core 2 at address 300 (pointer 4 wraps to core 2)
        req = 8'h04;
        set_addr(2, 16'd300);
        #1;
        check("oor_grant", 32'(grant), 32'h04);
        tick();
        check("oor_rvalid", 32'(rvalid), 32'h04);
        check("oor_rdata", 32'(rdata), 32'h0000);
        check("oor_rerr", 32'(rerr), 32'h1);
        req = '0;
        tick();
        check("idle_rvalid", 32'(rvalid), 32'h00);
        check("idle_rerr", 32'(rerr), 32'h0);

        // Out-of-range write must not alias onto address 44
        load(16'd300, 16'hDEAD);
        req = 8'h20;
        set_addr(5, 16'd44);
        tick();
        check("alias_rvalid", 32'(rvalid), 32'h20);
        check("alias_rdata", 32'(rdata), 32'h4444);
        check("alias_rerr", 32'(rerr), 32'h0);
        req = '0;
        tick();
        check("hold_rvalid", 32'(rvalid), 32'h00);
        check("hold_rdata", 32'(rdata), 32'h4444);

        // Asynchronous reset while a response is outstanding
        req = 8'h40;
        set_addr(6, 16'd12);
        #1;
        check("mid_grant", 32'(grant), 32'h40);
        tick();
        check("mid_rvalid", 32'(rvalid), 32'h40);
        check("mid_rdata", 32'(rdata), 32'hABCD);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rvalid", 32'(rvalid), 32'h00);
        check("arst_rdata", 32'(rdata), 32'h0000);
        check("arst_grant", 32'(grant), 32'h00);
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // After release: lowest requester wins, memory contents survived
        req = 8'h30;
        set_addr(4, 16'd0);
        set_addr(5, 16'd12);
        #1;
        check("post_grant", 32'(grant), 32'h10);
        tick();
        check("post_rvalid", 32'(rvalid), 32'h10);
        check("post_rdata", 32'(rdata), 32'h0100);
        req = 8'h20;
        #1;
        check("post2_grant", 32'(grant), 32'h20);
        tick();
        check("post2_rdata", 32'(rdata), 32'hABCD);
        req = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
